// File: rtl/lsu_bus_bridge.sv
// Bridges RV32I load/store requests onto a simple req/ack word bus.
// States: IDLE wait for request | REQ bus owned | RESP done pulse | FAULT fault pulse.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_stall,
  output logic        ls_done,
  output logic        ls_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;
  logic          legal, aligned, accept, timeout;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  always_comb begin
    legal = 1'b0;
    case (ls_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !ls_we;
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (ls_funct3[1:0])
      2'b01:   aligned = !ls_addr[0];
      2'b10:   aligned = (ls_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign accept  = (state == IDLE) && ls_valid && legal && aligned;
  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ls_wdata;
    case (ls_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ls_addr[1:0];
        wdata_c = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << ls_addr[1:0];
        wdata_c = {2{ls_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ls_wdata;
      end
    endcase
  end

  // Load data is aligned and extended at the ack edge, so ls_rdata is already valid in RESP.
  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    ls_done   = 1'b0;
    ls_fault  = 1'b0;
    ls_stall  = 1'b0;
    case (state)
      IDLE: begin
        ls_stall = ls_valid;
        if (ls_valid) state_nxt = (legal && aligned) ? REQ : FAULT;
      end
      REQ: begin
        bus_req  = 1'b1;
        bus_we   = we_q;
        ls_stall = 1'b1;
        if (bus_ack)      state_nxt = RESP;
        else if (timeout) state_nxt = FAULT;
      end
      RESP: begin
        ls_done   = 1'b1;
        state_nxt = IDLE;
      end
      FAULT: begin
        ls_fault  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      off_q     <= 2'd0;
      funct3_q  <= 3'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      ls_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= '0;
        we_q      <= ls_we;
        off_q     <= ls_addr[1:0];
        funct3_q  <= ls_funct3;
        bus_addr  <= {ls_addr[31:2], 2'b00};
        bus_wdata <= wdata_c;
        bus_be    <= be_c;
      end else if (state == REQ && !bus_ack) begin
        cnt <= cnt + CW'(1);
      end
      if (state == REQ && bus_ack && !we_q) ls_rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomized scoreboard bench for lsu_bus_bridge with a byte-level reference model.
module tb_lsu_bus_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ls_valid = 1'b0, ls_we = 1'b0;
  logic [2:0]  ls_funct3 = 3'd0;
  logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
  logic [31:0] ls_rdata;
  logic        ls_stall, ls_done, ls_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  lsu_bus_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_we(ls_we),
    .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_stall(ls_stall), .ls_done(ls_done),
    .ls_fault(ls_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          timeout;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_wait = 0;
  logic [31:0] cur_rdata = 32'd0;
  int          wait_cnt = 0;
  int          req_cycles = 0;
  logic [31:0] last_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour derived from access size, byte offset and signedness.
  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word, input int waits);
    exp_t e;
    int size, off;
    bit sgn;
    logic [31:0] mask, v;
    e = '{default: 0};
    e.we = we;
    e.waits = waits;
    off = int'(addr[1:0]);
    sgn = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    if (size == 0 || (we && f3[2]) || (off % size) != 0) begin
      e.fault = 1'b1;
      return e;
    end
    e.timeout = (waits >= TO);
    e.addr = addr & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = (i >= off) && (i < off + size);
      e.wdata[i*8 +: 8] = wdata[(i % size)*8 +: 8];
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size*8)) - 32'd1);
    v = (word >> (off*8)) & mask;
    if (sgn && v[size*8-1]) v = v | ~mask;
    e.rdata = v;
    return e;
  endfunction

  // Bus slave: acks after cur_wait stall cycles; toggles ack randomly while no request.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus_req) begin
        if (wait_cnt == cur_wait) begin
          bus_ack = 1'b1;
          bus_rdata = cur_rdata;
        end else begin
          bus_ack = 1'b0;
          bus_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_cycles = 0;
        last_rdata = 32'd0;
      end else begin
        chk("stall", 32'(ls_stall), 32'(bus_req || (ls_valid && !ls_done && !ls_fault)));
        if (bus_req) begin
          req_cycles++;
          if (sb.size() == 0) chk("unexpected_bus_req", 32'(bus_req), 32'd0);
          else begin
            e = sb[0];
            chk("req_on_fault_access", 32'(e.fault), 32'd0);
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_be", 32'(bus_be), 32'(e.be));
            chk("bus_we", 32'(bus_we), 32'(e.we));
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
          end
        end
        if (ls_done) begin
          if (sb.size() == 0) chk("unexpected_done", 32'(ls_done), 32'd0);
          else begin
            e = sb.pop_front();
            chk("done_kind", 32'(e.fault || e.timeout), 32'd0);
            chk("req_cycles_done", 32'(req_cycles), 32'(e.waits + 1));
            if (!e.we) begin
              chk("ls_rdata", ls_rdata, e.rdata);
              last_rdata = e.rdata;
            end else chk("rdata_hold_store", ls_rdata, last_rdata);
          end
          req_cycles = 0;
        end
        if (ls_fault) begin
          if (sb.size() == 0) chk("unexpected_fault", 32'(ls_fault), 32'd0);
          else begin
            e = sb.pop_front();
            chk("fault_kind", 32'(e.fault || e.timeout), 32'd1);
            chk("req_cycles_fault", 32'(req_cycles), e.timeout ? 32'(TO) : 32'd0);
            chk("rdata_hold_fault", ls_rdata, last_rdata);
          end
          req_cycles = 0;
        end
      end
    end
  end

  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word, input int waits);
    int n;
    sb.push_back(model(we, f3, addr, wdata, word, waits));
    cur_wait  = (waits >= TO) ? 1000 : waits;
    cur_rdata = word;
    ls_valid  = 1'b1;
    ls_we     = we;
    ls_funct3 = f3;
    ls_addr   = addr;
    ls_wdata  = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ls_done || ls_fault) && n < 64);
    if (n >= 64) chk("access_timeout", 32'(n), 32'd0);
    ls_valid = 1'b0;
    ls_addr  = $urandom;
    ls_funct3 = 3'($urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_done", 32'(ls_done), 32'd0);
    chk("rst_fault", 32'(ls_fault), 32'd0);
    chk("rst_stall", 32'(ls_stall), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 3);
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0);
    do_access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1);
    do_access(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 0);
    do_access(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'h1111_1111, 0);
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h2222_2222, TO);
    do_access(1'b0, 3'b101, 32'h0000_0302, 32'd0, 32'h8001_7FFF, TO - 1);
    do_access(1'b1, 3'b100, 32'h0000_0040, 32'hFFFF_FFFF, 32'd0, 0);
    do_access(1'b0, 3'b011, 32'h0000_0040, 32'd0, 32'd0, 0);

    // Reset while the bus request is outstanding.
    sb.push_back(model(1'b0, 3'b010, 32'h400, 32'd0, 32'd0, TO));
    cur_wait = 1000;
    ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h400;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_req_bus_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    ls_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_drop", 32'(bus_req), 32'd0);
    chk("rst_req_no_done", 32'(ls_done), 32'd0);
    chk("rst_req_no_fault", 32'(ls_fault), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'hCAFE_F00D, 2);

    for (int k = 0; k < 200; k++) begin
      int w;
      w = ($urandom_range(0, 15) == 0) ? TO : int'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom, w);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
